// File: rtl/ragnar_counter_bank.sv
// Bank of independent up/down counters with compare match, sticky overflow flags,
// and a valid/ready command port that also returns single-entry read responses.
module ragnar_counter_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [CHANNELS-1:0] tick_en,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [CW-1:0]       cmd_ch,
    input  logic [WIDTH-1:0]    cmd_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [WIDTH-1:0]    rd_data,
    output logic [CHANNELS-1:0] ovf,
    output logic [CHANNELS-1:0] match
);

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_LOAD      = 3'd1,
        OP_CLEAR     = 3'd2,
        OP_SET_CMP   = 3'd3,
        OP_READ      = 3'd4,
        OP_SET_MODE  = 3'd5,
        OP_CLR_FLAGS = 3'd6,
        OP_RSVD      = 3'd7
    } op_e;

    typedef struct packed {
        logic dir;  // 0 up, 1 down
        logic sat;  // 0 wrap, 1 saturate
    } mode_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0]    count_q [CHANNELS];
    logic [WIDTH-1:0]    count_d [CHANNELS];
    logic [WIDTH-1:0]    cmp_q   [CHANNELS];
    logic [WIDTH-1:0]    cmp_d   [CHANNELS];
    mode_t               mode_q  [CHANNELS];
    mode_t               mode_d  [CHANNELS];
    logic [CHANNELS-1:0] ovf_q, ovf_d;
    logic [CHANNELS-1:0] sel, blocked, tick;
    logic                rd_valid_q;
    logic [WIDTH-1:0]    rd_data_q;
    logic                read_hit;
    logic [WIDTH-1:0]    read_sel;
    logic                accept;
    op_e                 op;

    assign op        = op_e'(cmd_op);
    assign cmd_ready = !(rd_valid_q && !rd_ready);
    assign accept    = cmd_valid && cmd_ready;

    // NOTE: every variable driven here gets a default before any branch, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        read_hit = 1'b0;
        read_sel = '0;
        sel      = '0;
        blocked  = '0;
        tick     = '0;
        ovf_d    = ovf_q;
        for (int i = 0; i < CHANNELS; i++) begin
            count_d[i] = count_q[i];
            cmp_d[i]   = cmp_q[i];
            mode_d[i]  = mode_q[i];

            // A channel index beyond CHANNELS matches nothing, so such a command is a no-op.
            sel[i]     = accept && (cmd_ch == CW'(i));
            blocked[i] = sel[i] && !(op inside {OP_NOP, OP_READ, OP_RSVD});
            tick[i]    = ena && tick_en[i] && !blocked[i];

            if (tick[i]) begin
                if (!mode_q[i].dir) begin
                    if (count_q[i] == CNT_MAX) begin
                        ovf_d[i] = 1'b1;
                        if (!mode_q[i].sat) count_d[i] = '0;
                    end else begin
                        count_d[i] = count_q[i] + WIDTH'(1);
                    end
                end else begin
                    if (count_q[i] == '0) begin
                        ovf_d[i] = 1'b1;
                        if (!mode_q[i].sat) count_d[i] = CNT_MAX;
                    end else begin
                        count_d[i] = count_q[i] - WIDTH'(1);
                    end
                end
            end

            if (sel[i]) begin
                case (op)
                    OP_LOAD:      count_d[i] = cmd_data;
                    OP_CLEAR:     count_d[i] = '0;
                    OP_SET_CMP:   cmp_d[i]   = cmd_data;
                    OP_SET_MODE:  mode_d[i]  = '{dir: cmd_data[0], sat: cmd_data[1]};
                    OP_CLR_FLAGS: ovf_d[i]   = 1'b0;
                    OP_READ: begin
                        read_hit = 1'b1;
                        read_sel = count_q[i];
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the per-channel register arrays are small flop arrays, not RAM, so they are
    // reset explicitly; every element must come up in a known state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i] <= '0;
                cmp_q[i]   <= CNT_MAX;
                mode_q[i]  <= '0;
            end
            ovf_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples pre-edge values.
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i] <= count_d[i];
                cmp_q[i]   <= cmp_d[i];
                mode_q[i]  <= mode_d[i];
            end
            ovf_q <= ovf_d;
            if (read_hit) begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= read_sel;
            end else if (rd_ready) begin
                rd_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < CHANNELS; i++) match[i] = (count_q[i] == cmp_q[i]);
    end

    assign ovf      = ovf_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule
